// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the IF/MEM unified-memory arbiter.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package mem_arbiter_pkg;

  // Arbiter states; the encoding is visible in waveforms, so keep it fixed.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10,
    DONE   = 2'b11
  } state_t;

  // Which port currently owns the memory.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Width of the consecutive-data-grant counter; MAX_D_STREAK must fit in it.
  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto one handshake memory; data wins unless fetch is starved.
// Latency: request seen in IDLE at t -> MemReq from t+1; MemReady at k -> Ready/RD at k+1, IDLE at k+2.
// Backpressure: requesters hold Req and operands until their one-cycle Ready; memory stalls via MemReady.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 3
) (
  input  logic        CLK,
  input  logic        ResetN,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic        IReady,
  output logic [31:0] IRD,
  input  logic        DReq,
  input  logic        DWE,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWD,
  output logic        DReady,
  output logic [31:0] DRD,
  output logic        MemReq,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWD,
  input  logic        MemReady,
  input  logic [31:0] MemRD
);

  localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(MAX_D_STREAK);

  state_t                state;
  owner_t                owner;
  logic [STREAK_W-1:0]   streak;

  logic                  streak_full;
  logic                  grant_d;
  logic                  grant_i;

  // Grant decision for the IDLE cycle: data by default, fetch once data has won STREAK_CAP times in a row.
  always_comb begin
    streak_full = (streak == STREAK_CAP);
    grant_d     = DReq && !(IReq && streak_full);
    grant_i     = IReq && !grant_d;
  end

  // Arbiter FSM with the streak counter and every output registered.
  always_ff @(posedge CLK) begin
    if (!ResetN) begin
      state   <= IDLE;
      owner   <= OWN_I;
      streak  <= '0;
      IReady  <= 1'b0;
      IRD     <= '0;
      DReady  <= 1'b0;
      DRD     <= '0;
      MemReq  <= 1'b0;
      MemWE   <= 1'b0;
      MemAddr <= '0;
      MemWD   <= '0;
    end else begin
      case (state)
        IDLE: begin
          IReady <= 1'b0;
          DReady <= 1'b0;
          IRD    <= '0;
          DRD    <= '0;
          if (grant_d) begin
            state   <= BUSY_D;
            owner   <= OWN_D;
            MemReq  <= 1'b1;
            MemWE   <= DWE;
            MemAddr <= DAddr;
            MemWD   <= DWD;
            // Only a data grant that actually made fetch wait extends the streak.
            if (!IReq) begin
              streak <= '0;
            end else if (!streak_full) begin
              streak <= streak + 1'b1;
            end
          end else if (grant_i) begin
            state   <= BUSY_I;
            owner   <= OWN_I;
            MemReq  <= 1'b1;
            MemWE   <= 1'b0;
            MemAddr <= IAddr;
            MemWD   <= '0;
            streak  <= '0;
          end
        end

        BUSY_I, BUSY_D: begin
          // Mem* stay frozen until the memory finishes; the result goes only to the owner.
          if (MemReady) begin
            state  <= DONE;
            MemReq <= 1'b0;
            if (owner == OWN_D) begin
              DReady <= 1'b1;
              DRD    <= MemWE ? '0 : MemRD;
            end else begin
              IReady <= 1'b1;
              IRD    <= MemRD;
            end
          end
        end

        DONE: begin
          // Ready is a single-cycle pulse; read data is zeroed outside it.
          IReady <= 1'b0;
          DReady <= 1'b0;
          IRD    <= '0;
          DRD    <= '0;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port-to-one arbiter sharing a single multi-cycle, handshake-driven memory between the pipeline's instruction-fetch port and its data-access port. It sits between the IF/MEM stages and a unified memory that asserts a ready flag after a variable number of cycles, as the instruction memory does. Data accesses win by default; a starvation guard forces a fetch grant after a bounded run of data grants. Every access is latched at grant and completed with a one-cycle ready pulse to the winner.

## Interface
- MAX_D_STREAK, 3: consecutive data grants with IReq pending before a fetch grant is forced (1..15)
- CLK  in  1  clock; all state changes on rising edge
- ResetN  in  1  synchronous, active-low reset
- IReq  in  1  fetch request; held until IReady
- IAddr  in  32  fetch byte address
- IReady  out  1  one-cycle fetch completion pulse
- IRD  out  32  fetch data; valid only while IReady
- DReq  in  1  data request; held until DReady
- DWE  in  1  1 = write, 0 = read
- DAddr  in  32  data byte address
- DWD  in  32  write data
- DReady  out  1  one-cycle data completion pulse
- DRD  out  32  read data; valid only while DReady
- MemReq  out  1  memory access active
- MemWE  out  1  latched write enable
- MemAddr  out  32  latched address
- MemWD  out  32  latched write data
- MemReady  in  1  memory completion, one cycle
- MemRD  in  32  memory read data, valid with MemReady

## Operation
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE: samples IReq/DReq. Neither -> IDLE. Only one -> grant it. Both -> grant D, unless streak == MAX_D_STREAK, then grant I.
- On grant: latch address (and DWE, DWD for D; WE = 0 for I) into Mem* registers, record winner, go BUSY_x.
- BUSY_x: MemReq = 1, Mem* stable. Stay until MemReady = 1; then capture MemRD (0 for D writes) into the winner's RD register, go DONE.
- DONE: winner's Ready = 1 for exactly this cycle, MemReq = 0; next state IDLE unconditionally.
- Streak counter (4 bits): D grant with IReq high -> +1 (saturating at MAX_D_STREAK); any I grant -> 0; D grant with IReq low -> 0.
- Requester rule: Req and operands held constant from assertion until Ready; Req sampled again in IDLE, so a requester keeping Req high past Ready issues a new access.
- MemReady outside BUSY_x: ignored, no state or output change.
- IRD/DRD hold last value when Ready is low is NOT guaranteed; both drive 0 outside their Ready cycle.

## Timing
- Reset (ResetN = 0 at edge): state IDLE, streak 0, all outputs 0 (IReady, DReady, MemReq, MemWE, IRD, DRD, MemAddr, MemWD). Reset mid-access abandons it; a later MemReady is ignored.
- Request seen in IDLE at cycle t -> MemReq high from t+1.
- MemReady at cycle k -> Ready pulse and RD in k+1 (DONE) -> IDLE at k+2.
- Access latency = memory latency + 2 cycles; minimum gap between two grants is 1 IDLE cycle.
- MemReady in the first BUSY cycle is legal (1-cycle memory).
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Shared package: state encoding constants (IDLE=2'b00, BUSY_I=2'b01, BUSY_D=2'b10, DONE=2'b11) and the owner codes (OWN_I, OWN_D).
- Single module; the streak counter stays inline. No sub-module.
- Bench memory model: separate module with a fixed 4-cycle ready delay, word-addressed by A[7:2].

## Test plan
- Reset: ResetN = 0 for 2 cycles with IReq = DReq = 1 -> all outputs 0, MemReq stays 0 until 1 cycle after release.
- Single fetch: IReq, IAddr = 0x8, memory word 2 = 0x20020005, 4-cycle memory -> MemReq high 4 cycles, MemAddr = 0x8, IReady one cycle with IRD = 0x20020005, total 6 cycles.
- Collision: IReq and DReq (read 0x40) high together -> D granted first, DReady, then one IDLE cycle, then I granted.
- Starvation, MAX_D_STREAK = 3: IReq held, DReq re-asserted every IDLE -> grant order D, D, D, I, D.
- Write: DWE = 1, DAddr = 0x10, DWD = 0xDEADBEEF -> MemWE = 1, MemWD = 0xDEADBEEF, DReady pulse with DRD = 0; later read of 0x10 returns 0xDEADBEEF.
- Reset mid-access: ResetN low in the 2nd BUSY cycle, MemReady arrives 2 cycles later -> no Ready pulse, state IDLE, next request served normally.
